// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the iterative AES round controllers.
// Holds the FSM state encoding, Rcon constants and NR legality check.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;
    localparam int         ROUND_W   = 4;

    // AES-128/192/256 round counts are the only legal NR values.
    function automatic bit nr_is_legal(input int nr);
        return (nr == 10) || (nr == 12) || (nr == 14);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: sync clear, load of the first constant, or one
// GF(2^8) doubling step per advance.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (clr_i) begin
            rcon_d = 8'h00;
        end else if (load_i) begin
            rcon_d = RCON_INIT;
        end else if (adv_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcon_q <= 8'h00;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES encryption datapath: initial AddRoundKey,
// NR rounds, then a held result. Drives enables/selects only.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               abort,
    output logic               sel_init,
    output logic               state_en,
    output logic               key_load,
    output logic               key_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic               skip_mix,
    output logic [7:0]         rcon,
    output logic               busy,
    output ctrl_state_e        dbg_state
);

    if (!nr_is_legal(NR)) begin : g_bad_nr
        $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    // Handshakes: a block is taken when in_valid && in_ready at a rising
    // edge; the result is held with out_valid until out_ready is seen high.
    ctrl_state_e        state_q;
    logic [ROUND_W-1:0] round_idx_q;
    logic [ROUND_W-1:0] round_inc_d;
    logic               skip_mix_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               accept;
    logic               abort_kill;

    assign abort_kill  = abort && (state_q != IDLE);
    assign round_inc_d = round_idx_q + ROUND_W'(1);

    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        sel_init = 1'b0;
        state_en = 1'b0;
        key_load = 1'b0;
        key_en   = 1'b0;
        if (!rst) begin
            in_ready = !abort && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
            accept   = in_valid && in_ready;
            if (accept) begin
                sel_init = 1'b1;
                state_en = 1'b1;
                key_load = 1'b1;
            end else if (!abort && ((state_q == ROUND) || (state_q == FINAL))) begin
                state_en = 1'b1;
                key_en   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort_kill) begin
            state_q     <= IDLE;
            round_idx_q <= '0;
            skip_mix_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= ROUND;
                        round_idx_q <= ROUND_W'(1);
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                ROUND: begin
                    round_idx_q <= round_inc_d;
                    if (round_inc_d == LAST_ROUND) begin
                        state_q    <= FINAL;
                        skip_mix_q <= 1'b1;
                    end
                end
                FINAL: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    skip_mix_q  <= 1'b0;
                end
                DONE: begin
                    // A new block may be taken in the same cycle the result drains.
                    if (accept) begin
                        state_q     <= ROUND;
                        round_idx_q <= ROUND_W'(1);
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else if (out_ready) begin
                        state_q     <= IDLE;
                        round_idx_q <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (abort_kill),
        .load_i (accept),
        .adv_i  (state_q == ROUND),
        .rcon_o (rcon)
    );

    assign round_idx = round_idx_q;
    assign skip_mix  = skip_mix_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances share stimulus; each
// scenario checks one instance cycle by cycle against a round/Rcon model.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, out_ready, abort;

    logic        in_ready10, out_valid10, sel_init10, state_en10, key_load10, key_en10, skip_mix10, busy10;
    logic [3:0]  round_idx10;
    logic [7:0]  rcon10;
    ctrl_state_e dbg10;
    logic        in_ready14, out_valid14, sel_init14, state_en14, key_load14, key_en14, skip_mix14, busy14;
    logic [3:0]  round_idx14;
    logic [7:0]  rcon14;
    ctrl_state_e dbg14;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int rc_tab [15];

    // Observation vector: {busy, out_valid, skip_mix, round_idx, rcon, in_ready, sel_init, state_en, key_load, key_en}
    localparam logic [19:0] M_ALL  = 20'hFFFFF;
    localparam logic [19:0] M_NORC = 20'hFE01F;
    localparam logic [19:0] M_COMB = 20'h0001F;

    aes_round_ctrl #(.NR(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10),
        .out_valid(out_valid10), .out_ready(out_ready), .abort(abort),
        .sel_init(sel_init10), .state_en(state_en10), .key_load(key_load10),
        .key_en(key_en10), .round_idx(round_idx10), .skip_mix(skip_mix10),
        .rcon(rcon10), .busy(busy10), .dbg_state(dbg10)
    );

    aes_round_ctrl #(.NR(14)) dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready14),
        .out_valid(out_valid14), .out_ready(out_ready), .abort(abort),
        .sel_init(sel_init14), .state_en(state_en14), .key_load(key_load14),
        .key_en(key_en14), .round_idx(round_idx14), .skip_mix(skip_mix14),
        .rcon(rcon14), .busy(busy14), .dbg_state(dbg14)
    );

    function automatic logic [19:0] obs(input int nr);
        if (nr == 14)
            return {busy14, out_valid14, skip_mix14, round_idx14, rcon14,
                    in_ready14, sel_init14, state_en14, key_load14, key_en14};
        return {busy10, out_valid10, skip_mix10, round_idx10, rcon10,
                in_ready10, sel_init10, state_en10, key_load10, key_en10};
    endfunction

    function automatic logic [19:0] mk(input bit busy, input bit ov, input bit skip, input int ridx,
                                       input int rc, input bit ir, input bit si, input bit se,
                                       input bit kl, input bit ke);
        return {busy, ov, skip, 4'(ridx), 8'(rc), ir, si, se, kl, ke};
    endfunction

    // Rcon for round r is 2^(r-1) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    task automatic build_rc_tab();
        int v;
        v = 1;
        rc_tab[0] = 0;
        for (int r = 1; r <= 14; r++) begin
            rc_tab[r] = v;
            v = v * 2;
            if (v > 255) v = v ^ 283;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic accept_idle(input int nr, input logic [19:0] m, output int se);
        logic [19:0] o, e;
        in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1)); abort = 1'b0;
        settle();
        o = obs(nr);
        e = mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        checks++;
        if ((o & m) !== (e & m)) begin
            errors++;
            $display("FAIL accept nr=%0d: got %05h exp %05h [busy ov skip ridx rcon ir si se kl ke]", nr, o & m, e & m);
        end
        se = int'(o[2]);
        next_cyc();
    endtask

    task automatic run_rounds(input int nr, input int k_from, input int k_to, input bit hold, output int se_cnt);
        logic [19:0] o, e;
        se_cnt = 0;
        for (int k = k_from; k <= k_to; k++) begin
            in_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = hold ? 1'b1 : 1'($urandom_range(0, 1));
            abort     = 1'b0;
            settle();
            o = obs(nr);
            e = mk(1, 0, (k == nr), k, rc_tab[k], 0, 0, 1, 0, 1);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL round nr=%0d k=%0d: got %05h exp %05h [busy ov skip ridx rcon ir si se kl ke]", nr, k, o, e);
            end
            se_cnt += int'(o[2]);
            next_cyc();
        end
    endtask

    task automatic test_reset();
        logic [19:0] o, e;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; abort = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cyc();
            settle();
            o = obs(10);
            checks++;
            if (o !== 20'h0) begin
                errors++;
                $display("FAIL reset10 c=%0d: got %05h exp 00000", c, o);
            end
            o = obs(14);
            checks++;
            if (o !== 20'h0) begin
                errors++;
                $display("FAIL reset14 c=%0d: got %05h exp 00000", c, o);
            end
        end
        checks++;
        if (dbg10 !== IDLE || dbg14 !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d exp IDLE", dbg10, dbg14);
        end
        rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
        settle();
        o = obs(10);
        e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL idle_after_reset: got %05h exp %05h", o, e);
        end
        // Abort in IDLE only masks in_ready; nothing is accepted.
        abort = 1'b1; in_valid = 1'b1;
        settle();
        o = obs(10);
        checks++;
        if (o !== 20'h0) begin
            errors++;
            $display("FAIL abort_idle: got %05h exp 00000", o);
        end
        next_cyc();
        abort = 1'b0; in_valid = 1'b0;
        settle();
        o = obs(10);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_idle_next: got %05h exp %05h", o, e);
        end
    endtask

    task automatic test_single(input int nr);
        logic [19:0] o, e;
        int se_tot, se_r;
        do_reset();
        accept_idle(nr, M_ALL, se_tot);
        run_rounds(nr, 1, nr, 1'b0, se_r);
        se_tot += se_r;
        in_valid = 1'b0; out_ready = 1'b1;
        settle();
        o = obs(nr);
        e = mk(0, 1, 0, nr, rc_tab[nr], 1, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL done nr=%0d: got %05h exp %05h", nr, o, e);
        end
        se_tot += int'(o[2]);
        checks++;
        if (se_tot != nr + 1) begin
            errors++;
            $display("FAIL state_en_count nr=%0d: got %0d exp %0d", nr, se_tot, nr + 1);
        end
        next_cyc();
        settle();
        o = obs(nr);
        e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if ((o & M_NORC) !== (e & M_NORC)) begin
            errors++;
            $display("FAIL drained nr=%0d: got %05h exp %05h", nr, o & M_NORC, e & M_NORC);
        end
    endtask

    task automatic test_backpressure(input int nr);
        logic [19:0] o, e;
        int se, se_r;
        do_reset();
        accept_idle(nr, M_ALL, se);
        run_rounds(nr, 1, nr, 1'b0, se_r);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom_range(0, 1)); out_ready = 1'b0;
            settle();
            o = obs(nr);
            e = mk(0, 1, 0, nr, rc_tab[nr], 0, 0, 0, 0, 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hold nr=%0d c=%0d: got %05h exp %05h", nr, c, o, e);
            end
            next_cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        settle();
        o = obs(nr);
        e = mk(0, 1, 0, nr, rc_tab[nr], 1, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL release nr=%0d: got %05h exp %05h", nr, o, e);
        end
        next_cyc();
        settle();
        o = obs(nr);
        e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if ((o & M_NORC) !== (e & M_NORC)) begin
            errors++;
            $display("FAIL release_idle nr=%0d: got %05h exp %05h", nr, o & M_NORC, e & M_NORC);
        end
    endtask

    task automatic test_back_to_back(input int nr);
        logic [19:0] o, e;
        int se, se_r, last_acc;
        do_reset();
        accept_idle(nr, M_ALL, se);
        last_acc = cyc_n - 1;
        for (int b = 0; b < 3; b++) begin
            run_rounds(nr, 1, nr, 1'b1, se_r);
            in_valid = (b < 2); out_ready = 1'b1;
            settle();
            o = obs(nr);
            e = mk(0, 1, 0, nr, rc_tab[nr], 1, (b < 2), (b < 2), (b < 2), 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_done nr=%0d b=%0d: got %05h exp %05h", nr, b, o, e);
            end
            if (b < 2) begin
                checks++;
                if (!(o[4] && o[3]) || (cyc_n - last_acc) != nr + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing nr=%0d b=%0d: got %0d exp %0d", nr, b, cyc_n - last_acc, nr + 1);
                end
                last_acc = cyc_n;
            end
            next_cyc();
        end
        in_valid = 1'b0;
        settle();
        o = obs(nr);
        e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if ((o & M_NORC) !== (e & M_NORC)) begin
            errors++;
            $display("FAIL b2b_idle nr=%0d: got %05h exp %05h", nr, o & M_NORC, e & M_NORC);
        end
    endtask

    task automatic test_abort(input int nr, input int ab);
        logic [19:0] o, e;
        int se, se_r;
        do_reset();
        accept_idle(nr, M_ALL, se);
        run_rounds(nr, 1, ab - 1, 1'b0, se_r);
        abort = 1'b1; in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
        settle();
        o = obs(nr);
        e = mk(1, 0, (ab == nr), ab, rc_tab[ab], 0, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_cycle nr=%0d k=%0d: got %05h exp %05h", nr, ab, o, e);
        end
        next_cyc();
        abort = 1'b0; in_valid = 1'b0;
        settle();
        o = obs(nr);
        e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_idle nr=%0d k=%0d: got %05h exp %05h", nr, ab, o, e);
        end
        accept_idle(nr, M_ALL, se);
        run_rounds(nr, 1, nr, 1'b0, se_r);
        // Abort while the result waits: it is dropped.
        abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        settle();
        o = obs(nr);
        e = mk(0, 1, 0, nr, rc_tab[nr], 0, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_done nr=%0d: got %05h exp %05h", nr, o, e);
        end
        next_cyc();
        abort = 1'b0; in_valid = 1'b0;
        settle();
        o = obs(nr);
        e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_done_idle nr=%0d: got %05h exp %05h", nr, o, e);
        end
    endtask

    task automatic test_reset_mid(input int nr);
        logic [19:0] o, e;
        int se, se_r;
        do_reset();
        accept_idle(nr, M_ALL, se);
        run_rounds(nr, 1, 2, 1'b0, se_r);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; abort = 1'($urandom_range(0, 1));
        settle();
        o = obs(nr);
        checks++;
        if ((o & M_COMB) !== 20'h0) begin
            errors++;
            $display("FAIL rst_mid_comb nr=%0d: got %05h exp 00000", nr, o & M_COMB);
        end
        next_cyc();
        settle();
        o = obs(nr);
        checks++;
        if (o !== 20'h0) begin
            errors++;
            $display("FAIL rst_mid_regs nr=%0d: got %05h exp 00000", nr, o);
        end
        next_cyc();
        rst = 1'b0; abort = 1'b0;
        settle();
        o = obs(nr);
        e = mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rst_release nr=%0d: got %05h exp %05h", nr, o, e);
        end
        next_cyc();
        run_rounds(nr, 1, 2, 1'b0, se_r);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        build_rc_tab();
        test_reset();
        test_single(10);
        test_backpressure(10);
        test_back_to_back(10);
        test_abort(10, 5);
        test_abort(10, $urandom_range(1, 10));
        test_reset_mid(10);
        test_single(14);
        test_back_to_back(14);
        test_abort(14, $urandom_range(1, 14));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
